// File: rtl/spi_frame_decoder.sv
// Pops raw 64-bit MISO words, deinterleaves one lane into bytes (MSB first) and
// assembles header+payload hit frames for a valid/ready frame sink, with saturating counters.
module spi_frame_decoder #(
  parameter logic [7:0]  IDLE_BYTE   = 8'hBC,
  parameter int unsigned MAX_PAYLOAD = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lane_sel,
  input  logic [63:0] in_fifo_data,
  input  logic        in_fifo_empty,
  output logic        in_fifo_rd_en,
  output logic [63:0] frame_data,
  output logic [2:0]  frame_len,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);

  localparam logic [9:0] STALL_LAST = 10'd1023;  // 1024th consecutive empty cycle
  localparam logic [3:0] MAX_LEN    = 4'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_EMIT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q;
  logic        lane_q;
  logic [7:0]  hdr_q;
  logic [7:0]  payload_q [7];
  logic [2:0]  slot_q;
  logic [2:0]  rem_q;
  logic [9:0]  stall_q;

  logic        lane_eff;
  logic [15:0] seg;
  logic [15:0] seg_aligned;
  logic [7:0]  cur_byte;
  logic        consume;
  logic        hdr_ok;
  logic        take_hdr;
  logic        store_pay;
  logic        hdr_err;
  logic        trunc;
  logic        accept;

  // Lane choice is frozen for bytes 1..3 of a word.
  assign lane_eff = (byte_idx_q == 2'd0) ? lane_sel : lane_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    seg = 16'h0000;
    unique case (byte_idx_q)
      2'd0: seg = in_fifo_data[63:48];
      2'd1: seg = in_fifo_data[47:32];
      2'd2: seg = in_fifo_data[31:16];
      2'd3: seg = in_fifo_data[15:0];
      default: seg = 16'h0000;
    endcase
    // Shift the miso1 samples onto the odd positions so both lanes pick bits 15,13,..,1.
    seg_aligned = lane_eff ? {seg[14:0], 1'b0} : seg;
    cur_byte = 8'h00;
    for (int j = 0; j < 8; j++) begin
      cur_byte[j] = seg_aligned[2*j+1];
    end
  end

  assign consume       = !reset && !in_fifo_empty && (state_q != S_EMIT);
  assign in_fifo_rd_en = consume && (byte_idx_q == 2'd3);
  assign hdr_ok        = (cur_byte[2:0] != 3'd0) && ({1'b0, cur_byte[2:0]} <= MAX_LEN);

  always_comb begin
    state_d   = state_q;
    take_hdr  = 1'b0;
    store_pay = 1'b0;
    hdr_err   = 1'b0;
    trunc     = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (consume && cur_byte != IDLE_BYTE) begin
          if (hdr_ok) begin
            take_hdr = 1'b1;
            state_d  = S_PAYLOAD;
          end else begin
            hdr_err = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (consume) begin
          store_pay = 1'b1;
          if (rem_q == 3'd1) state_d = S_EMIT;
        end else if (in_fifo_empty && stall_q == STALL_LAST) begin
          trunc   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (frame_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= 2'd0;
      lane_q      <= 1'b0;
      hdr_q       <= 8'h00;
      slot_q      <= 3'd0;
      rem_q       <= 3'd0;
      stall_q     <= 10'd0;
      frame_count <= 16'h0000;
      err_count   <= 16'h0000;
      // NOTE: the payload buffer is only 7 bytes and drives frame_data directly, so it is reset.
      for (int i = 0; i < 7; i++) payload_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;

      if (consume) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd0) lane_q <= lane_sel;
      end

      stall_q <= (state_q == S_PAYLOAD && in_fifo_empty) ? stall_q + 10'd1 : 10'd0;

      if (take_hdr) begin
        hdr_q  <= cur_byte;
        rem_q  <= cur_byte[2:0];
        slot_q <= 3'd0;
      end

      if (store_pay) begin
        payload_q[slot_q] <= cur_byte;
        slot_q            <= slot_q + 3'd1;
        rem_q             <= rem_q - 3'd1;
      end

      // Accepted or abandoned frames leave a clean buffer so unused bytes read as 0.
      if (accept || trunc) begin
        hdr_q  <= 8'h00;
        slot_q <= 3'd0;
        rem_q  <= 3'd0;
        for (int i = 0; i < 7; i++) payload_q[i] <= 8'h00;
      end

      if (accept && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      if ((hdr_err || trunc) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  assign frame_valid = (state_q == S_EMIT);
  assign frame_len   = hdr_q[2:0];
  assign frame_data  = {hdr_q, payload_q[0], payload_q[1], payload_q[2], payload_q[3],
                        payload_q[4], payload_q[5], payload_q[6]};

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Self-checking bench for spi_frame_decoder: directed scenarios plus randomized frame streams
// scored against an item-level model of the expected frames and error count.
module tb_spi_frame_decoder;

  localparam logic [7:0] IDLE = 8'hBC;

  logic        clock = 1'b0;
  logic        reset;
  logic        lane_sel;
  logic [63:0] in_fifo_data;
  logic        in_fifo_empty;
  logic        in_fifo_rd_en;
  logic [63:0] frame_data;
  logic [2:0]  frame_len;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  always #5 clock = ~clock;

  spi_frame_decoder dut (
    .clock         (clock),
    .reset         (reset),
    .lane_sel      (lane_sel),
    .in_fifo_data  (in_fifo_data),
    .in_fifo_empty (in_fifo_empty),
    .in_fifo_rd_en (in_fifo_rd_en),
    .frame_data    (frame_data),
    .frame_len     (frame_len),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_count   (frame_count),
    .err_count     (err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] wq[$];      // words waiting in the readout FIFO
  bit          lq[$];      // lane each word was encoded on
  logic [7:0]  bq[$];      // lane byte stream under construction
  logic [66:0] exp_q[$];   // {len, data} of frames still to be accepted
  int          exp_frames;
  int          exp_err;
  int          wpos;       // bytes of the head word already consumed
  int          stall_pct;
  int          ready_pct;
  bit          last_valid;
  bit          prev_valid;
  bit          prev_ready;
  logic [63:0] prev_data;
  logic [2:0]  prev_len;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] encode(input logic [31:0] l0, input logic [31:0] l1);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        w[63 - 16*k - 2*(7-j)] = l0[24 - 8*k + j];
        w[62 - 16*k - 2*(7-j)] = l1[24 - 8*k + j];
      end
    end
    return w;
  endfunction

  task automatic pack(input bit rand_lane, input bit lane);
    logic [31:0] w32;
    bit          ln;
    while (bq.size() % 4 != 0) bq.push_back(IDLE);
    for (int i = 0; i < bq.size(); i += 4) begin
      w32 = {bq[i], bq[i+1], bq[i+2], bq[i+3]};
      ln  = rand_lane ? 1'($urandom) : lane;
      wq.push_back(ln ? encode($urandom, w32) : encode(w32, $urandom));
      lq.push_back(ln);
    end
    bq.delete();
  endtask

  task automatic expect_frame(input logic [2:0] len, input logic [63:0] data);
    exp_q.push_back({len, data});
    exp_frames++;
  endtask

  task automatic drive();
    bit stall;
    stall         = ($urandom_range(99) < stall_pct);
    in_fifo_empty = (wq.size() == 0) || stall;
    in_fifo_data  = (wq.size() != 0) ? wq[0] : {$urandom, $urandom};
    // Outside byte 0 of a live word lane_sel must be ignored, so scramble it there.
    if (!in_fifo_empty && wpos == 0) lane_sel = lq[0];
    else lane_sel = 1'($urandom);
    frame_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic cycle();
    bit          consuming;
    bit          pop_now;
    logic [66:0] e;
    @(negedge clock);
    consuming = !reset && !in_fifo_empty && !frame_valid;
    check("rd_en", in_fifo_rd_en, consuming && wpos == 3);
    pop_now    = in_fifo_rd_en;
    last_valid = frame_valid;
    if (!reset && prev_valid && !prev_ready) begin
      check("hold_valid", frame_valid, 1'b1);
      check("hold_data", frame_data, prev_data);
      check("hold_len", frame_len, prev_len);
    end
    if (!reset && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", frame_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", frame_data, e[63:0]);
        check("frame_len", frame_len, e[66:64]);
      end
    end
    prev_valid = !reset && frame_valid;
    prev_ready = frame_ready;
    prev_data  = frame_data;
    prev_len   = frame_len;
    if (consuming) wpos = (wpos + 1) % 4;
    @(posedge clock);
    #1;
    if (pop_now && wq.size() != 0) begin
      void'(wq.pop_front());
      void'(lq.pop_front());
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (wq.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", wq.size(), 0);
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("frames_pending", exp_q.size(), 0);
    run(4);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_count"}, frame_count, 16'(exp_frames));
    check({tag, "_err_count"}, err_count, 16'(exp_err));
  endtask

  task automatic gen_random(input int n_items);
    int          r;
    int          len;
    logic [7:0]  h;
    logic [7:0]  b;
    logic [63:0] d;
    for (int i = 0; i < n_items; i++) begin
      r = $urandom_range(99);
      if (r < 20) begin
        bq.push_back(IDLE);
      end else if (r < 32) begin
        h = {5'($urandom), 3'b000};
        bq.push_back(h);
        exp_err++;
      end else begin
        len = $urandom_range(7, 1);
        h   = {5'($urandom), 3'(len)};
        if (h == IDLE) h = h ^ 8'h80;
        d = '0;
        d[63:56] = h;
        bq.push_back(h);
        for (int p = 0; p < len; p++) begin
          b = ($urandom_range(9) == 0) ? IDLE : 8'($urandom);
          d[55 - 8*p -: 8] = b;
          bq.push_back(b);
        end
        expect_frame(3'(len), d);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    stall_pct  = 0;
    ready_pct  = 100;
    wpos       = 0;
    exp_frames = 0;
    exp_err    = 0;
    prev_valid = 1'b0;
    drive();
    run(3);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_rd_en", in_fifo_rd_en, 1'b0);
    check("rst_data", frame_data, 64'h0);
    check("rst_len", frame_len, 3'd0);
    check_counts("rst");
    reset = 1'b0;

    // Idle-only word: one pop, nothing emitted.
    bq = '{IDLE, IDLE, IDLE, IDLE};
    pack(1'b0, 1'b0);
    drain(50);
    run(5);
    check("t1_valid", frame_valid, 1'b0);
    check_counts("t1");

    // Two-byte frame: latency, then held under backpressure for 10 cycles.
    ready_pct = 0;
    bq = '{8'h0A, 8'h11, 8'h22, IDLE};
    expect_frame(3'd2, 64'h0A11_2200_0000_0000);
    pack(1'b0, 1'b0);
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_valid_early", last_valid, 1'b0);
    end
    cycle();
    check("t2_valid_rise", last_valid, 1'b1);
    check("t2_data", frame_data, 64'h0A11_2200_0000_0000);
    check("t2_len", frame_len, 3'd2);
    run(10);
    check("t3_word_held", wq.size(), 1);
    ready_pct = 100;
    drive();
    drain(20);
    settle(20);
    check_counts("t3");

    // Zero-length header, then a 7-byte frame across two words.
    bq = '{8'h08, 8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    exp_err++;
    expect_frame(3'd7, 64'h0F01_0203_0405_0607);
    pack(1'b0, 1'b0);
    drain(50);
    settle(50);
    check_counts("t4");

    // Truncation after 1024 empty cycles inside a frame.
    bq = '{IDLE, IDLE, 8'h0B, 8'h55};
    pack(1'b0, 1'b0);
    drain(20);
    run(1000);
    check("t5_no_early_trunc", err_count, 16'(exp_err));
    check("t5_valid", frame_valid, 1'b0);
    run(60);
    exp_err++;
    check_counts("t5_trunc");
    bq = '{8'h0A, 8'h11, 8'h22, IDLE};
    expect_frame(3'd2, 64'h0A11_2200_0000_0000);
    pack(1'b0, 1'b0);
    drain(20);
    settle(20);
    check_counts("t5_after");

    // Lane 1 frame, then reset in the middle of a payload.
    wq.push_back(encode({IDLE, IDLE, IDLE, IDLE}, {8'h09, 8'h5A, IDLE, IDLE}));
    lq.push_back(1'b1);
    expect_frame(3'd1, 64'h095A_0000_0000_0000);
    drain(20);
    settle(20);
    check_counts("t6_lane1");
    bq = '{8'h0F, 8'h11, 8'h22, 8'h33};
    pack(1'b0, 1'b0);
    drain(20);
    run(5);
    check("t6_mid_payload_valid", frame_valid, 1'b0);
    bq = '{8'h0A, 8'h11, 8'h22, IDLE};
    pack(1'b0, 1'b0);
    reset = 1'b1;
    drive();
    cycle();
    reset      = 1'b0;
    exp_frames = 0;
    exp_err    = 0;
    wpos       = 0;
    prev_valid = 1'b0;
    check("t6_word_not_popped", wq.size(), 1);
    check("t6_rst_valid", frame_valid, 1'b0);
    check("t6_rst_data", frame_data, 64'h0);
    check_counts("t6_rst");
    expect_frame(3'd2, 64'h0A11_2200_0000_0000);
    drain(20);
    settle(20);
    check_counts("t6_after");

    // Randomized streams with FIFO stalls, backpressure and per-word lane changes.
    for (int round = 0; round < 3; round++) begin
      stall_pct = 10 * (round + 1);
      ready_pct = 70 - 15 * round;
      gen_random(60);
      pack(1'b1, 1'b0);
      drain(20000);
      settle(2000);
      check_counts("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
